// File: rtl/dcache_wt_if.sv
// CPU data-port and data-memory signals of the write-through cache.
// slave is the cache side; master is the CPU/memory environment side.
interface dcache_wt_if;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one 32-bit word per line.
// Read hits complete in the request cycle; misses and stores stall until the memory acks.
module dcache_wt #(
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dcache_wt_if.slave  bus
);

  localparam int unsigned Lines = 1 << IDX_W;
  localparam int unsigned TagW  = 30 - IDX_W;

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [Lines-1:0]  valid_q, valid_d;
  logic [TagW-1:0]   tag_q  [Lines];
  logic [31:0]       data_q [Lines];

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              line_we;
  logic [31:0]       line_wdata;

  logic [IDX_W-1:0]  cpu_idx, mem_idx;
  logic [TagW-1:0]   cpu_tag, mem_tag;
  logic              cpu_hit, mem_hit;
  logic              unused_addr;

  assign cpu_idx     = bus.cpu_addr_i[IDX_W+1:2];
  assign cpu_tag     = bus.cpu_addr_i[31:IDX_W+2];
  assign cpu_hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  // The outstanding transaction's line is addressed through the held memory address.
  assign mem_idx     = mem_addr_q[IDX_W+1:2];
  assign mem_tag     = mem_addr_q[31:IDX_W+2];
  assign mem_hit     = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);
  assign unused_addr = ^{bus.cpu_addr_i[1:0], mem_addr_q[1:0]};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Tag/data storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tag_q[mem_idx]  <= mem_tag;
      data_q[mem_idx] <= line_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req_i && bus.cpu_we_i) begin
          state_d = StWrWait;
        end else if (bus.cpu_req_i && !cpu_hit) begin
          state_d = StRdWait;
        end
      end
      StRdWait: if (bus.mem_ack_i) state_d = StDone;
      StWrWait: if (bus.mem_ack_i) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next values and line writes
  always_comb begin
    valid_d     = valid_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    line_we     = 1'b0;
    line_wdata  = bus.mem_rdata_i;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req_i && (bus.cpu_we_i || !cpu_hit)) begin
          mem_req_d  = 1'b1;
          mem_we_d   = bus.cpu_we_i;
          mem_addr_d = {bus.cpu_addr_i[31:2], 2'b00};
          if (bus.cpu_we_i) mem_wdata_d = bus.cpu_wdata_i;
        end
      end
      StRdWait: begin
        if (bus.mem_ack_i) begin
          mem_req_d         = 1'b0;
          line_we           = 1'b1;
          valid_d[mem_idx]  = 1'b1;
          rdata_d           = bus.mem_rdata_i;
        end
      end
      StWrWait: begin
        if (bus.mem_ack_i) begin
          mem_req_d  = 1'b0;
          line_we    = mem_hit;
          line_wdata = mem_wdata_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.cpu_stall_o = 1'b0;
    bus.cpu_rdata_o = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req_i) begin
          if (!bus.cpu_we_i && cpu_hit) bus.cpu_rdata_o = data_q[cpu_idx];
          else                          bus.cpu_stall_o = 1'b1;
        end
      end
      StRdWait, StWrWait: bus.cpu_stall_o = 1'b1;
      StDone:   if (!mem_we_q) bus.cpu_rdata_o = rdata_q;
      default: ;
    endcase
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: a line-level cache/memory model predicts hit/miss, stall length,
// load data and memory traffic; a memory responder serves the DUT with configurable latency.
module tb_dcache_wt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_wt_if bus ();

  dcache_wt #(.IDX_W(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: per-index cached word address/data, plus the reference memory image.
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  logic [31:0] m_data  [16];
  logic [31:0] ref_mem  [logic [29:0]];
  logic [31:0] phys_mem [logic [29:0]];

  // Responder state
  int   resp_lat  = 1;
  int   rcnt      = 0;
  int   rd_count  = 0;
  int   wr_count  = 0;
  logic force_ack = 1'b0;

  // Expectations for the compare process
  bit          chk_en    = 1'b0;
  bit          exp_we    = 1'b0;
  bit          exp_mem   = 1'b0;
  logic [31:0] exp_maddr = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] exp_rdata = '0;

  function automatic logic [31:0] init_val(input logic [29:0] w);
    return {w, 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_val(w);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [29:0] w);
    if (phys_mem.exists(w)) return phys_mem[w];
    return init_val(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks on the resp_lat-th cycle that mem_req_o is seen high.
  always @(posedge clk) begin
    logic ack;
    #1;
    ack = 1'b0;
    if (bus.mem_req_o && !rst) begin
      rcnt++;
      if (rcnt == resp_lat) begin
        ack = 1'b1;
        if (bus.mem_we_o) begin
          phys_mem[bus.mem_addr_o[31:2]] = bus.mem_wdata_o;
          wr_count++;
        end else begin
          bus.mem_rdata_i = phys_rd(bus.mem_addr_o[31:2]);
          rd_count++;
        end
      end
    end else begin
      rcnt = 0;
    end
    bus.mem_ack_i = ack | force_ack;
  end

  // Compare process: load data on release cycles and memory request contents.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (bus.cpu_req_i && !bus.cpu_stall_o && !exp_we)
        check("load_rdata", bus.cpu_rdata_o, exp_rdata);
      if (bus.mem_req_o) begin
        check("mem_req_expected", {31'd0, exp_mem}, 32'd1);
        check("mem_addr", bus.mem_addr_o, exp_maddr);
        check("mem_we", {31'd0, bus.mem_we_o}, {31'd0, exp_we});
        if (exp_we) check("mem_wdata", bus.mem_wdata_o, exp_wdata);
      end
    end
  end

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, output int stalls, output logic [31:0] rd);
    int  idx;
    bit  hit;
    int  exp_st;
    int  rd0;
    int  wr0;
    bit  done;
    idx       = int'(addr[5:2]);
    hit       = m_valid[idx] && (m_word[idx] == addr[31:2]);
    exp_we    = we;
    exp_mem   = we || !hit;
    exp_maddr = {addr[31:2], 2'b00};
    exp_wdata = wd;
    exp_rdata = hit ? m_data[idx] : ref_rd(addr[31:2]);
    exp_st    = (!we && hit) ? 0 : 1 + lat;
    resp_lat  = lat;
    rd0       = rd_count;
    wr0       = wr_count;
    @(posedge clk); #1;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wd;
    chk_en          = 1'b1;
    stalls = 0;
    rd     = '0;
    done   = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall_o) begin
        rd   = bus.cpu_rdata_o;
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    if (!done) check("access_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b0;
    chk_en        = 1'b0;
    check("stall_cycles", stalls, exp_st);
    check("mem_writes", wr_count - wr0, {31'd0, we});
    check("mem_reads", rd_count - rd0, {31'd0, (!we && !hit)});
    if (we) begin
      ref_mem[addr[31:2]] = wd;
      if (hit) m_data[idx] = wd;
    end else if (!hit) begin
      m_valid[idx] = 1'b1;
      m_word[idx]  = addr[31:2];
      m_data[idx]  = exp_rdata;
    end
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_stall"}, {31'd0, bus.cpu_stall_o}, 32'd0);
    check({tag, "_mem_req"}, {31'd0, bus.mem_req_o}, 32'd0);
    check({tag, "_rdata"}, bus.cpu_rdata_o, 32'd0);
  endtask

  initial begin
    int          st;
    logic [31:0] rd;
    bit          seen;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    ref_mem[30'h40]  = 32'hDEAD_BEEF;
    phys_mem[30'h40] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    idle_checks("reset");
    check("reset_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
    check("reset_mem_addr", bus.mem_addr_o, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    idle_checks("post_reset");

    // Load miss with 3-cycle memory, then hit
    access(1'b0, 32'h100, '0, 3, st, rd);
    check("t1_stall_lit", st, 32'd4);
    check("t1_data_lit", rd, 32'hDEAD_BEEF);
    access(1'b0, 32'h100, '0, 3, st, rd);
    check("t1_hit_stall_lit", st, 32'd0);
    check("t1_hit_data_lit", rd, 32'hDEAD_BEEF);

    // Store hit updates line, write-through
    access(1'b1, 32'h100, 32'h1234_5678, 2, st, rd);
    check("t2_store_stall_lit", st, 32'd3);
    check("t2_phys_mem", phys_rd(30'h40), 32'h1234_5678);
    access(1'b0, 32'h100, '0, 2, st, rd);
    check("t2_hit_lit", rd, 32'h1234_5678);

    // Store miss does not allocate (min latency), load then misses
    access(1'b1, 32'h200, 32'hCAFE_0200, 1, st, rd);
    check("t3_min_stall_lit", st, 32'd2);
    access(1'b0, 32'h200, '0, 2, st, rd);
    check("t3_miss_stall_lit", st, 32'd3);
    check("t3_data_lit", rd, 32'hCAFE_0200);

    // Aliasing on index 1
    access(1'b0, 32'h004, '0, 1, st, rd);
    access(1'b0, 32'h044, '0, 2, st, rd);
    check("t4_alias_miss_lit", st, 32'd3);
    access(1'b0, 32'h004, '0, 1, st, rd);
    check("t4_evicted_lit", st, 32'd2);
    check("t4_data_lit", rd, 32'h5A5A_0004);
    access(1'b0, 32'h3C0, '0, 4, st, rd);
    access(1'b0, 32'h3C0, '0, 4, st, rd);

    // Reset while in the read-wait state
    resp_lat = 20;
    @(posedge clk); #1;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h008;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.mem_req_o;
    end
    check("t5_reached_wait", {31'd0, seen}, 32'd1);
    #2;
    rst = 1'b1;
    bus.cpu_req_i = 1'b0;
    #1;
    check("t5_async_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("t5_async_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    force_ack = 1'b1;
    @(negedge clk);
    idle_checks("t5_late_ack");
    @(posedge clk); #2;
    force_ack = 1'b0;
    access(1'b0, 32'h004, '0, 2, st, rd);
    check("t5_miss_after_reset_lit", st, 32'd3);

    // Spurious ack in idle leaves line intact
    @(posedge clk); #2;
    force_ack = 1'b1;
    @(negedge clk);
    idle_checks("t6_spurious");
    @(posedge clk); #2;
    force_ack = 1'b0;
    access(1'b0, 32'h004, '0, 2, st, rd);
    check("t6_still_hit_lit", st, 32'd0);
    check("t6_data_lit", rd, 32'h5A5A_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
